// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between two byte producers.
// Each byte is held on tx_byte, started with a tx_send pulse and then awaits tx_ready.
// A watchdog abandons any byte whose completion strobe never arrives.
module uart_tx_arbiter #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 2,
  parameter int unsigned TIMEOUT   = 4095
) (
  input  logic       clock25,
  input  logic       reset_n,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  output logic       a_done,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       b_done,
  output logic [7:0] tx_byte,
  output logic       tx_send,
  input  logic       tx_ready,
  output logic       busy,
  output logic       owner,
  output logic       err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_LEN - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    pulse_cnt;
  logic [7:0]    gap_cnt;
  logic          last;
  logic          grant_a;
  logic          grant_b;

  // Contention goes to whichever requester was not served last.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE) begin
      grant_a = a_valid & (~b_valid | last);
      grant_b = b_valid & (~a_valid | ~last);
    end
  end

  assign a_ready = grant_a & reset_n;
  assign b_ready = grant_b & reset_n;
  assign busy    = (state != IDLE);

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tx_send   <= 1'b0;
      tx_byte   <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      err       <= 1'b0;
      timer     <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (a_ready || b_ready) begin
            tx_byte   <= b_ready ? b_data : a_data;
            owner     <= b_ready;
            last      <= b_ready;
            timer     <= '0;
            pulse_cnt <= '0;
            tx_send   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          timer     <= timer + TW'(1);
          pulse_cnt <= pulse_cnt + 4'd1;
          // An early strobe still counts as completion and cuts the pulse short.
          if (tx_ready) begin
            tx_send <= 1'b0;
            a_done  <= ~owner;
            b_done  <= owner;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (pulse_cnt == PULSE_LAST) begin
            tx_send <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + TW'(1);
          if (tx_ready) begin
            a_done  <= ~owner;
            b_done  <= owner;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (timer == TIMER_LAST) begin
            err     <= 1'b1;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_cnt == GAP_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
